// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: state encoding, default width,
// and the Hi/Lo write-select codes also used by the multicycle controller.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HILO_KEEP = 2'd0,
        HILO_MULT = 2'd1,
        HILO_DIV  = 2'd2
    } hilo_sel_t;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the remainder/quotient
// pair left by one, trial-subtract the divisor, and restore when it would go negative.
module div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The remainder stays below the divisor, so one extra bit holds the shifted value
    // and its top bit doubles as the borrow of the trial subtraction.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) for the
// multicycle MIPS datapath; one bit per cycle, then Hi/Lo are written and Done pulses.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_t           state, next_state;
    hilo_sel_t        hilo_sel;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             dz_flag;

    logic [2*WIDTH:0] prod, booth_next;
    logic [WIDTH:0]   booth_hi, booth_m, booth_sum;
    logic [WIDTH-1:0] mcand;

    logic [WIDTH-1:0] rem, quo, dvsr, rem_nx, quo_nx;
    logic             neg_quo, neg_rem;

    assign last = (count == CNT_W'(ITER - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every variable gets a default first; a branch that skipped one would infer a latch.
    always_comb begin
        next_state = state;
        hilo_sel   = HILO_KEEP;
        Busy       = (state != IDLE);
        Done       = (state == FINISH);
        DivZero    = (state == FINISH) && dz_flag;
        unique case (state)
            IDLE: begin
                if (MultCtrl)     next_state = MULT;
                else if (DivCtrl) next_state = (B == '0) ? FINISH : DIV;
            end
            MULT: if (last) begin
                next_state = FINISH;
                hilo_sel   = HILO_MULT;
            end
            DIV: if (last) begin
                next_state = FINISH;
                hilo_sel   = HILO_DIV;
            end
            FINISH: next_state = IDLE;
        endcase
    end

    // Booth step with a sign-extended high word so -M cannot overflow for M = most-negative.
    always_comb begin
        booth_hi = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        booth_m  = {mcand[WIDTH-1], mcand};
        case (prod[1:0])
            2'b01:   booth_sum = booth_hi + booth_m;
            2'b10:   booth_sum = booth_hi - booth_m;
            default: booth_sum = booth_hi;
        endcase
        booth_next = {booth_sum, prod[WIDTH:1]};
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvsr),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_ff @(posedge clock) begin
        if (Reset) begin
            count   <= '0;
            dz_flag <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
        end else begin
            count <= ((state == MULT || state == DIV) && !last) ? count + CNT_W'(1) : '0;
            if (state == IDLE && (MultCtrl || DivCtrl))
                dz_flag <= !MultCtrl && (B == '0);
            case (hilo_sel)
                HILO_MULT: begin
                    Hi <= booth_next[2*WIDTH:WIDTH+1];
                    Lo <= booth_next[WIDTH:1];
                end
                HILO_DIV: begin
                    Hi <= neg_rem ? -rem_nx : rem_nx;
                    Lo <= neg_quo ? -quo_nx : quo_nx;
                end
                default: ;
            endcase
        end
    end

    // NOTE: iteration registers carry no reset; they are always loaded at start before use.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: begin
                if (MultCtrl) begin
                    prod  <= {{WIDTH{1'b0}}, B, 1'b0};
                    mcand <= A;
                end else if (DivCtrl) begin
                    rem     <= '0;
                    quo     <= A[WIDTH-1] ? -A : A;
                    dvsr    <= B[WIDTH-1] ? -B : B;
                    neg_quo <= A[WIDTH-1] ^ B[WIDTH-1];
                    neg_rem <= A[WIDTH-1];
                end
            end
            MULT: prod <= booth_next;
            DIV: begin
                rem <= rem_nx;
                quo <= quo_nx;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide responder for the multicycle MIPS datapath.
- Started by the control unit's MultCtrl/DivCtrl pulses; takes operands from the A/B registers.
- Iterates one bit per cycle, then writes the Hi/Lo registers and pulses Done.
- The controller waits in its mult/div state until Done.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles per operation.

Ports:
- clock  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- A  in  WIDTH  multiplicand / dividend (rs).
- B  in  WIDTH  multiplier / divisor (rt).
- MultCtrl  in  1  start signed multiply; sampled only in IDLE.
- DivCtrl  in  1  start signed divide; sampled only in IDLE.
- Hi  out  WIDTH  product high word / remainder.
- Lo  out  WIDTH  product low word / quotient.
- Busy  out  1  high from the cycle after start through FINISH.
- Done  out  1  one-cycle pulse when Hi/Lo have just been updated.
- DivZero  out  1  pulses with Done when a divide had B==0.

Behaviour:
- Interface: one clock, `clock`; reset `Reset` is synchronous and active-high.
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0.
- Reset mid-operation aborts immediately; no Hi/Lo update and no Done.

States:
- IDLE -> MULT when MultCtrl=1.
- IDLE -> DIV when DivCtrl=1 and B!=0.
- IDLE -> FINISH when DivCtrl=1 and B==0; DivZero flag is latched.
- MULT/DIV -> FINISH when counter reaches ITER-1.
- FINISH -> IDLE, always.

Start rules:
- MultCtrl and DivCtrl both high in IDLE: multiply wins.
- Starts while not in IDLE are ignored; no queuing.
- Operands are latched at the start edge, so later A/B changes have no effect.

MULT (radix-2 Booth):
- Datapath: 2*WIDTH+1-bit product register {P_hi, P_lo, q-1} and multiplicand M.
- Each cycle: add M, subtract M, or do nothing per {q0, q-1}, then arithmetic shift right by 1.
- Result is the full signed 2*WIDTH product.
- 0x80000000 * 0x80000000 must give the correct product 0x4000000000000000.

DIV (signed restoring on magnitudes):
- Take |A| and |B|; each cycle shift the remainder/quotient pair left, trial-subtract, and restore on a negative result.
- At FINISH, negate the quotient if sign(A)!=sign(B); negate the remainder if A<0 (MIPS truncation toward zero).
- 0x80000000 / -1 yields Lo=0x80000000, Hi=0, with no flag.

FINISH:
- Hi/Lo are written on the edge entering FINISH.
- Done=1 (and DivZero if flagged) during the FINISH cycle; Busy=1 there.
- Divide by zero: Hi/Lo are left unchanged.

Latency:
- Start sampled at edge N; Done high during the cycle after edge N+ITER (33 cycles after start for WIDTH=32).
- Divide by zero: Done during the cycle after edge N.
- Back-to-back: a new start is accepted in the cycle after FINISH, in IDLE.

Width rules:
- All arithmetic is two's complement, internally WIDTH+1 bits to hold the sign and carry.
- The counter is clog2(ITER) bits and wraps only via the state change.

Decomposition:
- Package mult_div_pkg holds:
  - the state encoding IDLE=2'd0, MULT=2'd1, DIV=2'd2, FINISH=2'd3;
  - DEFAULT_WIDTH=32;
  - the ALU-independent Hi/Lo write-select constants shared with the controller.
- One combinational sub-module, div_step: given remainder, quotient and divisor, returns the next remainder/quotient after one shift-subtract-restore step. The Booth step stays inline.

Test Plan:
- A=7, B=-3 (0xFFFFFFFD), MultCtrl pulse -> Done 33 cycles later, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Busy low the following cycle.
- A=B=0x80000000, MultCtrl -> Hi=0x40000000, Lo=0x00000000; then A=0x12345678, B=1 -> Hi=0, Lo=0x12345678.
- A=-7, B=2, DivCtrl -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); A=7, B=-2 -> Lo=0xFFFFFFFD, Hi=1.
- A=5, B=0, DivCtrl -> Done and DivZero high in the cycle after start; Hi/Lo keep their previous values; a second divide 100/7 then gives Lo=14, Hi=2, DivZero=0.
- MultCtrl and DivCtrl high together with A=6, B=4 -> multiply performed (Lo=24); a DivCtrl pulse at cycle 10 of the operation is ignored and exactly one Done occurs.
- Reset asserted at cycle 15 of a multiply -> next cycle Hi=Lo=0, Busy=0, and no Done; a new MultCtrl afterwards completes normally in 33 cycles.
